aes_key_schedule: RTL and testbench

Parametrised AES key-schedule engine for 128-, 192- and 256-bit keys. It expands a cipher key one 32-bit word per clock into an internal round-key store. Afterwards it serves any round key by index, in encryption or decryption order, through a registered read port. It sits beside the cipher and inverse-cipher datapaths and replaces the fixed 128-bit, decrypt-only schedule with one engine shared by both directions.

---
 rtl/aes_pkg.sv | 54 +++++
 rtl/aes_subword.sv | 32 +++
 rtl/aes_key_schedule.sv | 173 +++++++++++++++++
 tb/tb_aes_key_schedule.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES package: key-size derivation, rcon table, key-schedule FSM states
// and GF(2^8) helpers reused by the cipher and inverse-cipher datapaths.
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_READY
    } ks_state_t;

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic int ks_nk(input int key_bits);
        return key_bits / 32;
    endfunction

    function automatic int ks_nr(input int key_bits);
        return ks_nk(key_bits) + 6;
    endfunction

    function automatic int ks_nw(input int key_bits);
        return 4 * (ks_nr(key_bits) + 1);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Row 0 of the column sits in bits 31:24.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a, x2, x4, x8;
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int b = 0; b < 4; b++) begin
            a     = col[31-8*b -: 8];
            x2    = xtime(a);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[b] = x8 ^ a;
            mb[b] = x8 ^ x2 ^ a;
            md[b] = x8 ^ x4 ^ a;
            me[b] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: four parallel AES S-box lookups on a 32-bit word.
module aes_subword (
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    always_comb begin
        o_word = '0;
        for (int b = 0; b < 4; b++) begin
            o_word[8*b +: 8] = SBOX[i_word[8*b +: 8]];
        end
    end

endmodule

// File: rtl/aes_key_schedule.sv
// AES key schedule for 128/192/256-bit keys: one expanded word per clock into
// a round-key store, read back through a registered port in either order.
// Optional macro AES_KS_EQINV_EN: decrypt-order middle rounds are returned
// through InvMixColumns for the equivalent inverse cipher.
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [KEY_BITS-1:0] key_in,
    input  logic                key_valid,
    output logic                key_ready,
    output logic                busy,
    output logic                keys_ready,
    input  logic                rk_req,
    input  logic [3:0]          rk_idx,
    input  logic                rk_dec,
    output logic [127:0]        rk_out,
    output logic                rk_valid,
    output logic                rk_err
);
    localparam int NK = ks_nk(KEY_BITS);
    localparam int NR = ks_nr(KEY_BITS);
    localparam int NW = ks_nw(KEY_BITS);

    generate
        if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
            $error("aes_key_schedule: KEY_BITS must be 128, 192 or 256");
        end
    endgenerate

    ks_state_t    r_state;
    ks_state_t    w_next;
    logic [5:0]   r_i;
    logic [2:0]   r_j;
    logic [3:0]   r_rc;
    logic         r_keys_ready;
    logic [31:0]  r_w [NW];
    logic [127:0] r_rk_out;
    logic         r_rk_valid;
    logic         r_rk_err;

    logic         w_accept;
    logic         w_last;
    logic [31:0]  w_prev;
    logic [31:0]  w_back;
    logic [31:0]  w_sub_in;
    logic [31:0]  w_sub_out;
    logic [31:0]  w_temp;
    logic [31:0]  w_new;
    logic         w_rd_bad;
    logic [3:0]   w_rd_r;
    logic [5:0]   w_rd_base;
    logic [127:0] w_rd_key;
    logic [127:0] w_rd_data;

    assign w_accept   = key_valid && key_ready;
    assign w_last     = (r_i == 6'(NW - 1));
    assign keys_ready = r_keys_ready;
    assign rk_out     = r_rk_out;
    assign rk_valid   = r_rk_valid;
    assign rk_err     = r_rk_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        key_ready = 1'b1;
        busy      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next = ST_EXPAND;
            end
            ST_EXPAND: begin
                key_ready = 1'b0;
                busy      = 1'b1;
                if (w_last) w_next = ST_READY;
            end
            ST_READY: begin
                if (w_accept) w_next = ST_EXPAND;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // r_j tracks i mod NK and r_rc the rcon index, so no divider is needed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_i          <= '0;
            r_j          <= '0;
            r_rc         <= '0;
            r_keys_ready <= 1'b0;
        end else if (w_accept) begin
            r_i          <= 6'(NK);
            r_j          <= '0;
            r_rc         <= '0;
            r_keys_ready <= 1'b0;
        end else if (r_state == ST_EXPAND) begin
            r_i <= r_i + 6'd1;
            r_j <= (r_j == 3'(NK - 1)) ? 3'd0 : r_j + 3'd1;
            if (r_j == 3'd0) r_rc <= r_rc + 4'd1;
            if (w_last) r_keys_ready <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int k = 0; k < NK; k++) begin
                r_w[k] <= key_in[KEY_BITS-1-32*k -: 32];
            end
        end else if (r_state == ST_EXPAND) begin
            r_w[r_i] <= w_new;
        end
    end

    assign w_prev   = r_w[r_i - 6'd1];
    assign w_back   = r_w[r_i - 6'(NK)];
    assign w_sub_in = (r_j == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    aes_subword u_subword (
        .i_word (w_sub_in),
        .o_word (w_sub_out)
    );

    always_comb begin
        w_temp = w_prev;
        if (r_j == 3'd0) begin
            w_temp = w_sub_out ^ {RCON[r_rc], 24'h0};
        end else if (NK == 8 && r_j == 3'd4) begin
            w_temp = w_sub_out;
        end
        w_new = w_back ^ w_temp;
    end

    assign w_rd_bad  = !r_keys_ready || (rk_idx > 4'(NR));
    assign w_rd_r    = rk_dec ? (4'(NR) - rk_idx) : rk_idx;
    assign w_rd_base = {w_rd_r, 2'b00};
    assign w_rd_key  = {r_w[w_rd_base], r_w[w_rd_base + 6'd1],
                        r_w[w_rd_base + 6'd2], r_w[w_rd_base + 6'd3]};

`ifdef AES_KS_EQINV_EN
    always_comb begin
        w_rd_data = w_rd_key;
        if (rk_dec && rk_idx != 4'd0 && rk_idx < 4'(NR)) begin
            w_rd_data = {inv_mix_col(w_rd_key[127:96]), inv_mix_col(w_rd_key[95:64]),
                         inv_mix_col(w_rd_key[63:32]),  inv_mix_col(w_rd_key[31:0])};
        end
    end
`else
    assign w_rd_data = w_rd_key;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rk_out   <= '0;
            r_rk_valid <= 1'b0;
            r_rk_err   <= 1'b0;
        end else begin
            r_rk_valid <= rk_req;
            r_rk_err   <= rk_req && w_rd_bad;
            if (rk_req) r_rk_out <= w_rd_bad ? '0 : w_rd_data;
        end
    end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule at all three key sizes, against a
// FIPS-197 style key-expansion model with an S-box derived from GF(2^8).
module tb_aes_key_schedule;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [2:0][255:0] keyIn;
    logic [2:0] keyValid;
    logic [2:0] rkReq;
    logic [2:0] rkDec;
    logic [2:0][3:0] rkIdx;
    wire  [2:0] keyReady;
    wire  [2:0] busy;
    wire  [2:0] keysReady;
    wire  [2:0] rkValid;
    wire  [2:0] rkErr;
    wire  [2:0][127:0] rkOut;

    int nCompared = 0;
    int nMismatched = 0;
    logic [7:0]  sboxTab [256];
    logic [31:0] refW [60];

    always #5 clk = ~clk;

    aes_key_schedule #(.KEY_BITS(128)) dut128 (
        .clk(clk), .reset_n(reset_n), .key_in(keyIn[0][255:128]), .key_valid(keyValid[0]),
        .key_ready(keyReady[0]), .busy(busy[0]), .keys_ready(keysReady[0]),
        .rk_req(rkReq[0]), .rk_idx(rkIdx[0]), .rk_dec(rkDec[0]),
        .rk_out(rkOut[0]), .rk_valid(rkValid[0]), .rk_err(rkErr[0]));

    aes_key_schedule #(.KEY_BITS(192)) dut192 (
        .clk(clk), .reset_n(reset_n), .key_in(keyIn[1][255:64]), .key_valid(keyValid[1]),
        .key_ready(keyReady[1]), .busy(busy[1]), .keys_ready(keysReady[1]),
        .rk_req(rkReq[1]), .rk_idx(rkIdx[1]), .rk_dec(rkDec[1]),
        .rk_out(rkOut[1]), .rk_valid(rkValid[1]), .rk_err(rkErr[1]));

    aes_key_schedule #(.KEY_BITS(256)) dut256 (
        .clk(clk), .reset_n(reset_n), .key_in(keyIn[2]), .key_valid(keyValid[2]),
        .key_ready(keyReady[2]), .busy(busy[2]), .keys_ready(keysReady[2]),
        .rk_req(rkReq[2]), .rk_idx(rkIdx[2]), .rk_dec(rkDec[2]),
        .rk_out(rkOut[2]), .rk_valid(rkValid[2]), .rk_err(rkErr[2]));

    // Reference model: shift-and-add GF multiply, S-box from inverse + affine map
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = '0; aa = a; bb = b;
        for (int n = 0; n < 8; n++) begin
            if (bb[0]) p ^= aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    task automatic buildSbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = '0;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv;
            for (int r = 1; r < 5; r++) s ^= (inv << r) | (inv >> (8 - r));
            sboxTab[x] = s ^ 8'h63;
        end
    endtask

    function automatic int nkOf(input int s);
        return 4 + 2 * s;
    endfunction

    function automatic int nrOf(input int s);
        return nkOf(s) + 6;
    endfunction

    function automatic logic [31:0] subWordRef(input logic [31:0] w);
        return {sboxTab[w[31:24]], sboxTab[w[23:16]], sboxTab[w[15:8]], sboxTab[w[7:0]]};
    endfunction

    task automatic buildRef(input int s, input logic [255:0] key);
        int nk;
        int nw;
        logic [31:0] t;
        logic [7:0] rc;
        nk = nkOf(s);
        nw = 4 * (nrOf(s) + 1);
        for (int i = 0; i < nk; i++) refW[i] = key[255-32*i -: 32];
        for (int i = nk; i < nw; i++) begin
            t = refW[i-1];
            if (i % nk == 0) begin
                rc = 8'h01;
                for (int n = 1; n < i / nk; n++) rc = gmul(rc, 8'h02);
                t = subWordRef({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            end else if (nk > 6 && i % nk == 4) begin
                t = subWordRef(t);
            end
            refW[i] = refW[i-nk] ^ t;
        end
    endtask

    function automatic logic [31:0] invMixRef(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

    // Expected {valid, err, key} for a legal-state read from the current model.
    function automatic logic [129:0] expectRead(input int s, input int idx, input logic dec);
        int r;
        logic [127:0] v;
        if (idx > nrOf(s)) return {2'b11, 128'h0};
        r = dec ? nrOf(s) - idx : idx;
        v = {refW[4*r], refW[4*r+1], refW[4*r+2], refW[4*r+3]};
`ifdef AES_KS_EQINV_EN
        if (dec && idx >= 1 && idx < nrOf(s)) begin
            v = {invMixRef(v[127:96]), invMixRef(v[95:64]), invMixRef(v[63:32]), invMixRef(v[31:0])};
        end
`endif
        return {2'b10, v};
    endfunction

    function automatic logic [255:0] randKey();
        logic [255:0] k;
        for (int w = 0; w < 8; w++) k[32*w +: 32] = $urandom;
        return k;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic loadKey(input int s, input logic [255:0] key);
        keyIn[s] = key;
        keyValid[s] = 1'b1;
        tick();
        keyValid[s] = 1'b0;
    endtask

    task automatic readReq(input int s, input int idx, input logic dec);
        rkReq[s] = 1'b1;
        rkIdx[s] = 4'(idx);
        rkDec[s] = dec;
        tick();
        rkReq[s] = 1'b0;
    endtask

    task automatic waitReady(input int s, output int cycles);
        cycles = 0;
        while (!keysReady[s] && cycles < 200) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        for (int s = 0; s < 3; s++) begin
            nCompared++;
            if ({keyReady[s], busy[s], keysReady[s], rkValid[s], rkErr[s], rkOut[s]} !== {5'b10000, 128'h0}) begin
                nMismatched++;
                $display("[TB] FAIL reset_state inst%0d: got rdy/busy/kr/val/err=%b out=%h expected 10000 out=0",
                         s, {keyReady[s], busy[s], keysReady[s], rkValid[s], rkErr[s]}, rkOut[s]);
            end
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_idle_read();
        for (int s = 0; s < 3; s++) begin
            readReq(s, 0, 1'b0);
            nCompared++;
            if ({rkValid[s], rkErr[s], rkOut[s]} !== {2'b11, 128'h0}) begin
                nMismatched++;
                $display("[TB] FAIL idle_read inst%0d: got val/err=%b out=%h expected 11 out=0",
                         s, {rkValid[s], rkErr[s]}, rkOut[s]);
            end
            tick();
            nCompared++;
            if (rkValid[s] !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL valid_pulse inst%0d: got %b expected 0", s, rkValid[s]);
            end
        end
    endtask

    task automatic test_known_vectors();
        logic [255:0] keys [3];
        logic [127:0] lastRk [3];
        int lat [3];
        int cycles;
        keys[0] = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        keys[1] = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
        keys[2] = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        lastRk[0] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        lastRk[1] = 128'he98ba06f448c773c8ecc720401002202;
        lastRk[2] = 128'hfe4890d1e6188d0b046df344706c631e;
        lat = '{40, 46, 52};
        for (int s = 0; s < 3; s++) begin
            loadKey(s, keys[s]);
            nCompared++;
            if ({keyReady[s], busy[s], keysReady[s]} !== 3'b010) begin
                nMismatched++;
                $display("[TB] FAIL accept_state inst%0d: got rdy/busy/kr=%b expected 010",
                         s, {keyReady[s], busy[s], keysReady[s]});
            end
            waitReady(s, cycles);
            nCompared++;
            if (cycles !== lat[s]) begin
                nMismatched++;
                $display("[TB] FAIL kv_latency inst%0d: got %0d cycles expected %0d", s, cycles, lat[s]);
            end
            readReq(s, nrOf(s), 1'b0);
            nCompared++;
            if ({rkValid[s], rkErr[s], rkOut[s]} !== {2'b10, lastRk[s]}) begin
                nMismatched++;
                $display("[TB] FAIL kv_last_round inst%0d: got val/err=%b out=%h expected 10 out=%h",
                         s, {rkValid[s], rkErr[s]}, rkOut[s], lastRk[s]);
            end
            readReq(s, 0, 1'b1);
            nCompared++;
            if ({rkValid[s], rkErr[s], rkOut[s]} !== {2'b10, lastRk[s]}) begin
                nMismatched++;
                $display("[TB] FAIL kv_dec_idx0 inst%0d: got val/err=%b out=%h expected 10 out=%h",
                         s, {rkValid[s], rkErr[s]}, rkOut[s], lastRk[s]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] key;
        logic [129:0] exp;
        int cycles;
        int idx;
        logic dec;
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < 2; k++) begin
                key = randKey();
                loadKey(s, key);
                waitReady(s, cycles);
                nCompared++;
                if (cycles !== 4 * (nrOf(s) + 1) - nkOf(s)) begin
                    nMismatched++;
                    $display("[TB] FAIL rand_latency inst%0d: got %0d expected %0d",
                             s, cycles, 4 * (nrOf(s) + 1) - nkOf(s));
                end
                buildRef(s, key);
                for (int n = 0; n < 24; n++) begin
                    idx = (n <= nrOf(s)) ? n : int'($urandom_range(0, 15));
                    dec = 1'($urandom);
                    rkReq[s] = 1'b1;
                    rkIdx[s] = 4'(idx);
                    rkDec[s] = dec;
                    tick();
                    exp = expectRead(s, idx, dec);
                    nCompared++;
                    if ({rkValid[s], rkErr[s], rkOut[s]} !== exp) begin
                        nMismatched++;
                        $display("[TB] FAIL b2b_read inst%0d idx=%0d dec=%b: got %h expected %h",
                                 s, idx, dec, {rkValid[s], rkErr[s], rkOut[s]}, exp);
                    end
                end
                rkReq[s] = 1'b0;
                tick();
                nCompared++;
                if (rkValid[s] !== 1'b0) begin
                    nMismatched++;
                    $display("[TB] FAIL b2b_valid_drop inst%0d: got %b expected 0", s, rkValid[s]);
                end
            end
        end
    endtask

    task automatic test_illegal_busy();
        logic [255:0] key;
        logic [129:0] exp;
        int cycles;
        key = randKey();
        loadKey(0, key);
        repeat (3) tick();
        readReq(0, 3, 1'b0);
        nCompared++;
        if ({rkValid[0], rkErr[0], rkOut[0], busy[0]} !== {2'b11, 128'h0, 1'b1}) begin
            nMismatched++;
            $display("[TB] FAIL expand_read: got val/err=%b out=%h busy=%b expected 11 out=0 busy=1",
                     {rkValid[0], rkErr[0]}, rkOut[0], busy[0]);
        end
        keyIn[0] = ~key;
        keyValid[0] = 1'b1;
        repeat (5) tick();
        keyValid[0] = 1'b0;
        waitReady(0, cycles);
        nCompared++;
        if (cycles !== 31) begin
            nMismatched++;
            $display("[TB] FAIL busy_key_ignored_latency: got %0d expected 31", cycles);
        end
        buildRef(0, key);
        readReq(0, 10, 1'b0);
        exp = expectRead(0, 10, 1'b0);
        nCompared++;
        if ({rkValid[0], rkErr[0], rkOut[0]} !== exp) begin
            nMismatched++;
            $display("[TB] FAIL busy_key_ignored_data: got %h expected %h", {rkValid[0], rkErr[0], rkOut[0]}, exp);
        end
        readReq(0, 11, 1'b0);
        nCompared++;
        if ({rkValid[0], rkErr[0], rkOut[0]} !== {2'b11, 128'h0}) begin
            nMismatched++;
            $display("[TB] FAIL idx11_read: got val/err=%b out=%h expected 11 out=0", {rkValid[0], rkErr[0]}, rkOut[0]);
        end
        readReq(0, 15, 1'b1);
        nCompared++;
        if ({rkValid[0], rkErr[0], rkOut[0], busy[0], keysReady[0]} !== {2'b11, 128'h0, 2'b01}) begin
            nMismatched++;
            $display("[TB] FAIL idx15_dec_read: got val/err=%b out=%h busy/kr=%b expected 11 out=0 busy/kr=01",
                     {rkValid[0], rkErr[0]}, rkOut[0], {busy[0], keysReady[0]});
        end
    endtask

    task automatic test_simultaneous();
        logic [255:0] keyB;
        logic [129:0] exp;
        int cycles;
        keyB = randKey();
        exp = expectRead(0, 0, 1'b0);
        keyIn[0] = keyB;
        keyValid[0] = 1'b1;
        rkReq[0] = 1'b1;
        rkIdx[0] = 4'd0;
        rkDec[0] = 1'b0;
        tick();
        keyValid[0] = 1'b0;
        rkReq[0] = 1'b0;
        nCompared++;
        if ({rkValid[0], rkErr[0], rkOut[0], keysReady[0]} !== {exp, 1'b0}) begin
            nMismatched++;
            $display("[TB] FAIL simul_old_read: got %h kr=%b expected %h kr=0",
                     {rkValid[0], rkErr[0], rkOut[0]}, keysReady[0], exp);
        end
        waitReady(0, cycles);
        nCompared++;
        if (cycles !== 40) begin
            nMismatched++;
            $display("[TB] FAIL simul_latency: got %0d expected 40", cycles);
        end
        buildRef(0, keyB);
        readReq(0, 5, 1'b1);
        exp = expectRead(0, 5, 1'b1);
        nCompared++;
        if ({rkValid[0], rkErr[0], rkOut[0]} !== exp) begin
            nMismatched++;
            $display("[TB] FAIL simul_new_read: got %h expected %h", {rkValid[0], rkErr[0], rkOut[0]}, exp);
        end
    endtask

    task automatic test_reset_mid();
        logic [255:0] keyD;
        logic [129:0] exp;
        int cycles;
        loadKey(0, randKey());
        repeat (20) tick();
        reset_n = 1'b0;
        #1;
        nCompared++;
        if ({keyReady[0], busy[0], keysReady[0], rkValid[0]} !== 4'b1000) begin
            nMismatched++;
            $display("[TB] FAIL async_reset: got rdy/busy/kr/val=%b expected 1000",
                     {keyReady[0], busy[0], keysReady[0], rkValid[0]});
        end
        tick();
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        nCompared++;
        if ({busy[0], keysReady[0]} !== 2'b00) begin
            nMismatched++;
            $display("[TB] FAIL post_reset_idle: got busy/kr=%b expected 00", {busy[0], keysReady[0]});
        end
        keyD = randKey();
        loadKey(0, keyD);
        waitReady(0, cycles);
        nCompared++;
        if (cycles !== 40) begin
            nMismatched++;
            $display("[TB] FAIL reset_mid_latency: got %0d expected 40", cycles);
        end
        buildRef(0, keyD);
        rkReq[0] = 1'b1;
        for (int idx = 0; idx <= 10; idx++) begin
            rkIdx[0] = 4'(idx);
            rkDec[0] = 1'b0;
            tick();
            exp = expectRead(0, idx, 1'b0);
            nCompared++;
            if ({rkValid[0], rkErr[0], rkOut[0]} !== exp) begin
                nMismatched++;
                $display("[TB] FAIL reset_mid_read idx=%0d: got %h expected %h",
                         idx, {rkValid[0], rkErr[0], rkOut[0]}, exp);
            end
        end
        rkReq[0] = 1'b0;
        tick();
    endtask

    initial begin
        keyIn = '0;
        keyValid = '0;
        rkReq = '0;
        rkDec = '0;
        rkIdx = '0;
        buildSbox();
        test_reset();
        test_idle_read();
        test_known_vectors();
        test_back_to_back();
        test_illegal_busy();
        test_simultaneous();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
